// File: rtl/reg_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin register-bus arbiter.
package reg_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int idx_width(input int num_req);
    int w;
    w = $clog2(num_req);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/rr_ptr_select.sv
// Rotating-priority encoder: first asserted request at or above the pointer,
// wrapping around to the lower indices.
module rr_ptr_select
  import reg_rr_arbiter_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Scan from the farthest offset down so the nearest request is written last.
  always_comb begin
    int k;
    k       = 0;
    idx_o   = {IdxW{1'b0}};
    valid_o = 1'b0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      k = int'(ptr_i) + off;
      if (k >= NumReq) begin
        k = k - NumReq;
      end else begin
        k = k;
      end
      idx_o   = req_i[k] ? IdxW'(k) : idx_o;
      valid_o = valid_o | req_i[k];
    end
  end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target between NumReq requesters.
// Optional watchdog abort of hung transactions: define REG_RR_ARBITER_TIMEOUT_EN.
module reg_rr_arbiter
  import reg_rr_arbiter_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq-1:0]          in_valid_i,
  input  logic [NumReq-1:0]          in_write_i,
  input  logic [NumReq*AW-1:0]       in_addr_i,
  input  logic [NumReq*DW-1:0]       in_wdata_i,
  input  logic [NumReq*DW/8-1:0]     in_wstrb_i,
  output logic [NumReq-1:0]          in_ready_o,
  output logic [DW-1:0]              in_rdata_o,
  output logic                       in_error_o,
  output logic                       out_valid_o,
  output logic                       out_write_o,
  output logic [AW-1:0]              out_addr_o,
  output logic [DW-1:0]              out_wdata_o,
  output logic [DW/8-1:0]            out_wstrb_o,
  input  logic                       out_ready_i,
  input  logic [DW-1:0]              out_rdata_i,
  input  logic                       out_error_i,
  output logic [$clog2(NumReq)-1:0]  gnt_idx_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int IdxW = idx_width(NumReq);
  localparam int SW   = DW / 8;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_s;
  logic [IdxW-1:0] ptr_next_s;
  logic            any_s;
  logic            busy_s;
  logic            gnt_valid_s;
  logic            out_valid_s;
  logic            done_s;
  logic            timeout_fire_s;

  rr_ptr_select #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_sel (
    .req_i  (in_valid_i),
    .ptr_i  (ptr_q),
    .idx_o  (win_s),
    .valid_o(any_s)
  );

  assign busy_s      = (state_q == BUSY);
  assign gnt_valid_s = in_valid_i[gnt_q];
  assign out_valid_s = busy_s & gnt_valid_s & ~timeout_fire_s;
  assign done_s      = out_valid_s & out_ready_i;
  assign ptr_next_s  = (gnt_q == IdxW'(NumReq - 1)) ? {IdxW{1'b0}} : gnt_q + IdxW'(1);

`ifdef REG_RR_ARBITER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A real completion in the expiry cycle wins over the abort.
  assign timeout_fire_s = busy_s & gnt_valid_s & ~out_ready_i &
                          (cnt_q == CntW'(TimeoutCycles));

  // Watchdog count of BUSY cycles spent waiting on the target.
  always_comb begin
    cnt_d = {CntW{1'b0}};
    if (busy_s && gnt_valid_s && !done_s && !timeout_fire_s) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = {CntW{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CntW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_s;

  assign timeout_fire_s   = 1'b0;
  assign unused_timeout_s = TimeoutCycles[0];
`endif

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= {IdxW{1'b0}};
      ptr_q   <= {IdxW{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for completion, abandon or abort in BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          gnt_d   = win_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (done_s || timeout_fire_s) begin
          ptr_d   = ptr_next_s;
          state_d = IDLE;
        end else if (!gnt_valid_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: forward the granted request and route the response back to it.
  always_comb begin
    out_valid_o = out_valid_s;
    busy_o      = busy_s;
    gnt_idx_o   = gnt_q;
    timeout_o   = timeout_fire_s;
    in_ready_o  = {NumReq{1'b0}};
    if (out_valid_s) begin
      out_write_o = in_write_i[gnt_q];
      out_addr_o  = in_addr_i[int'(gnt_q)*AW +: AW];
      out_wdata_o = in_wdata_i[int'(gnt_q)*DW +: DW];
      out_wstrb_o = in_wstrb_i[int'(gnt_q)*SW +: SW];
    end else begin
      out_write_o = 1'b0;
      out_addr_o  = {AW{1'b0}};
      out_wdata_o = {DW{1'b0}};
      out_wstrb_o = {SW{1'b0}};
    end
    if (busy_s) begin
      in_rdata_o = timeout_fire_s ? {DW{1'b0}} : out_rdata_i;
      in_error_o = timeout_fire_s | out_error_i;
    end else begin
      in_rdata_o = {DW{1'b0}};
      in_error_o = 1'b0;
    end
    if (done_s || timeout_fire_s) begin
      in_ready_o[gnt_q] = 1'b1;
    end else begin
      in_ready_o = {NumReq{1'b0}};
    end
  end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed, table-driven bench for reg_rr_arbiter (4 requesters, 32-bit bus).
module tb_reg_rr_arbiter;

  logic         clk_i;
  logic         rst_ni;
  logic [3:0]   in_valid_i;
  logic [3:0]   in_write_i;
  logic [127:0] in_addr_i;
  logic [127:0] in_wdata_i;
  logic [15:0]  in_wstrb_i;
  logic [3:0]   in_ready_o;
  logic [31:0]  in_rdata_o;
  logic         in_error_o;
  logic         out_valid_o;
  logic         out_write_o;
  logic [31:0]  out_addr_o;
  logic [31:0]  out_wdata_o;
  logic [3:0]   out_wstrb_o;
  logic         out_ready_i;
  logic [31:0]  out_rdata_i;
  logic         out_error_i;
  logic [1:0]   gnt_idx_o;
  logic         busy_o;
  logic         timeout_o;

  reg_rr_arbiter #(
    .NumReq(4), .AW(32), .DW(32), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_write_i(in_write_i), .in_addr_i(in_addr_i),
    .in_wdata_i(in_wdata_i), .in_wstrb_i(in_wstrb_i),
    .in_ready_o(in_ready_o), .in_rdata_o(in_rdata_o), .in_error_o(in_error_o),
    .out_valid_o(out_valid_o), .out_write_o(out_write_o), .out_addr_o(out_addr_o),
    .out_wdata_o(out_wdata_o), .out_wstrb_o(out_wstrb_o),
    .out_ready_i(out_ready_i), .out_rdata_i(out_rdata_i), .out_error_i(out_error_i),
    .gnt_idx_o(gnt_idx_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  valid;
    logic        rdy;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  e_ready;
    logic        e_ov;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] addr_tab[4];
  logic [31:0] wdata_tab[4];
  logic [3:0]  wstrb_tab[4];
  logic [3:0]  wr_tab;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic r, input logic e, input logic [31:0] d,
                     input logic [3:0] er, input logic eov, input logic [1:0] eg,
                     input logic eb, input logic [31:0] ed, input logic ee);
    vec_t x;
    x = '{v, r, e, d, er, eov, eg, eb, ed, ee};
    vecs.push_back(x);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic r, input logic e, input logic [31:0] d);
    in_valid_i  = v;
    out_ready_i = r;
    out_error_i = e;
    out_rdata_i = d;
  endtask

  // Compact check of the handshake-level outputs.
  task automatic chk_core(input string tag, input logic [3:0] er, input logic eov,
                          input logic [1:0] eg, input logic eb);
    chk({tag, " in_ready"}, 32'(in_ready_o), 32'(er));
    chk({tag, " out_valid"}, 32'(out_valid_o), 32'(eov));
    chk({tag, " gnt_idx"}, 32'(gnt_idx_o), 32'(eg));
    chk({tag, " busy"}, 32'(busy_o), 32'(eb));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    addr_tab = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0010, 32'h0000_0300};
    wr_tab   = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wdata_tab[k] = 32'hD000_0000 | 32'(k);
      wstrb_tab[k] = 4'b0001 << k;
      in_addr_i[k*32 +: 32]  = addr_tab[k];
      in_wdata_i[k*32 +: 32] = wdata_tab[k];
      in_wstrb_i[k*4 +: 4]   = wstrb_tab[k];
    end
    in_write_i = wr_tab;
    rst_ni     = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 32'h0);

    //   valid    rdy   err   rdata         e_ready  ov    gnt    busy  e_rdata       e_err
    add(4'b0100, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0);
    add(4'b0100, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 2'd2, 1'b1, 32'h0,        1'b0);
    add(4'b0100, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 2'd2, 1'b1, 32'h0,        1'b0);
    add(4'b0100, 1'b1, 1'b0, 32'h0000CAFE, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h0000CAFE, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0);
    add(4'b1001, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0);
    add(4'b1001, 1'b1, 1'b0, 32'h00001234, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h00001234, 1'b0);
    add(4'b0001, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd3, 1'b0, 32'h0,        1'b0);
    add(4'b0001, 1'b1, 1'b0, 32'h00005678, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00005678, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h000000A1, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b0000, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h000000A1, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b0000, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h000000A1, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b0000, 1'b0, 2'd3, 1'b0, 32'h0,        1'b0);
    add(4'b1111, 1'b1, 1'b0, 32'h000000A1, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h000000A1, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0);
    add(4'b0010, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0);
    add(4'b0010, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 2'd1, 1'b1, 32'h0,        1'b0);
    add(4'b0000, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd1, 1'b1, 32'h0,        1'b0);
    add(4'b1011, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0);
    add(4'b1011, 1'b1, 1'b1, 32'h00000BAD, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h00000BAD, 1'b1);
    add(4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0);

    // Reset values, sampled while reset is held.
    step();
    step();
    chk_core("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("reset out_addr", out_addr_o, 32'h0);
    chk("reset timeout", 32'(timeout_o), 32'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step();
      drive(vecs[i].valid, vecs[i].rdy, vecs[i].err, vecs[i].rdata);
      #1;
      chk_core($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_ov, vecs[i].e_gnt, vecs[i].e_busy);
      chk($sformatf("row%0d in_rdata", i), in_rdata_o, vecs[i].e_rdata);
      chk($sformatf("row%0d in_error", i), 32'(in_error_o), 32'(vecs[i].e_err));
      chk($sformatf("row%0d timeout", i), 32'(timeout_o), 32'h0);
      chk($sformatf("row%0d out_addr", i), out_addr_o,
          vecs[i].e_ov ? addr_tab[vecs[i].e_gnt] : 32'h0);
      chk($sformatf("row%0d out_wdata", i), out_wdata_o,
          vecs[i].e_ov ? wdata_tab[vecs[i].e_gnt] : 32'h0);
      chk($sformatf("row%0d out_wstrb", i), 32'(out_wstrb_o),
          vecs[i].e_ov ? 32'(wstrb_tab[vecs[i].e_gnt]) : 32'h0);
      chk($sformatf("row%0d out_write", i), 32'(out_write_o),
          vecs[i].e_ov ? 32'(wr_tab[vecs[i].e_gnt]) : 32'h0);
    end

    // Asynchronous reset in the middle of a granted transaction (pointer is 2 here).
    step();
    drive(4'b1000, 1'b0, 1'b0, 32'h0);
    #1;
    chk_core("rst idle", 4'b0000, 1'b0, 2'd1, 1'b0);
    step();
    chk_core("rst busy", 4'b0000, 1'b1, 2'd3, 1'b1);
    drive(4'b1001, 1'b1, 1'b0, 32'h0000_5555);
    rst_ni = 1'b0;
    #1;
    chk_core("rst async", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("rst async out_addr", out_addr_o, 32'h0);
    chk("rst async in_rdata", in_rdata_o, 32'h0);
    out_ready_i = 1'b0;
    step();
    rst_ni = 1'b1;
    #1;
    chk_core("post-rst idle", 4'b0000, 1'b0, 2'd0, 1'b0);
    step();
    drive(4'b1001, 1'b1, 1'b0, 32'h0000_0001);
    #1;
    chk_core("post-rst gnt0", 4'b0001, 1'b1, 2'd0, 1'b1);
    step();
    drive(4'b1000, 1'b0, 1'b0, 32'h0);
    #1;
    chk_core("post-rst gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    step();
    drive(4'b1000, 1'b1, 1'b0, 32'h0000_0003);
    #1;
    chk_core("post-rst gnt3", 4'b1000, 1'b1, 2'd3, 1'b1);
    step();
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    #1;
    chk_core("post-rst end", 4'b0000, 1'b0, 2'd3, 1'b0);

    // Target that never answers; pointer is 0 here.
    step();
    drive(4'b0001, 1'b0, 1'b0, 32'h0000_BEEF);
    #1;
    chk_core("hang idle", 4'b0000, 1'b0, 2'd3, 1'b0);
`ifdef REG_RR_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      step();
      chk_core($sformatf("hang wait%0d", c), 4'b0000, 1'b1, 2'd0, 1'b1);
      chk($sformatf("hang wait%0d timeout", c), 32'(timeout_o), 32'h0);
    end
    step();
    chk_core("hang abort", 4'b0001, 1'b0, 2'd0, 1'b1);
    chk("hang abort timeout", 32'(timeout_o), 32'h1);
    chk("hang abort error", 32'(in_error_o), 32'h1);
    chk("hang abort rdata", in_rdata_o, 32'h0);
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    step();
    chk_core("hang after", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("hang after timeout", 32'(timeout_o), 32'h0);
`else
    for (int c = 0; c < 20; c++) begin
      step();
      chk_core($sformatf("hang wait%0d", c), 4'b0000, 1'b1, 2'd0, 1'b1);
      chk($sformatf("hang wait%0d timeout", c), 32'(timeout_o), 32'h0);
    end
    step();
    drive(4'b0001, 1'b1, 1'b0, 32'h0000_BEEF);
    #1;
    chk_core("hang late ack", 4'b0001, 1'b1, 2'd0, 1'b1);
    chk("hang late rdata", in_rdata_o, 32'h0000_BEEF);
    step();
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    #1;
    chk_core("hang after", 4'b0000, 1'b0, 2'd0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_rr_arbiter.md
Name: reg_rr_arbiter

Overview:
- Round-robin arbiter sharing one register-bus target port between NumReq register-bus requesters (e.g. several AXI-to-reg converters feeding one peripheral such as the PLIC).
- Holds one transaction at a time.
  - Grant is registered.
  - Request fields are forwarded from the granted requester.
  - The response is routed back only to that requester.
- Optional watchdog terminates hung transactions with an error.

Parameters:
- NumReq, 4, number of requesters (≥2).
- AW, 32, address width.
- DW, 32, data width; strobe width DW/8.
- TimeoutCycles, 255, BUSY cycles without out_ready_i before abort (watchdog only; ≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  NumReq  per-requester valid.
- in_write_i  in  NumReq  per-requester write flag.
- in_addr_i  in  NumReq*AW  packed addresses; requester k at [k*AW +: AW].
- in_wdata_i  in  NumReq*DW  packed write data.
- in_wstrb_i  in  NumReq*DW/8  packed strobes.
- in_ready_o  out  NumReq  per-requester completion pulse.
- in_rdata_o  out  DW  shared read data, valid with in_ready_o.
- in_error_o  out  1  shared error, valid with in_ready_o.
- out_valid_o  out  1  target valid.
- out_write_o  out  1  target write flag.
- out_addr_o  out  AW  target address.
- out_wdata_o  out  DW  target write data.
- out_wstrb_o  out  DW/8  target strobes.
- out_ready_i  in  1  target completion.
- out_rdata_i  in  DW  target read data.
- out_error_i  in  1  target error.
- gnt_idx_o  out  $clog2(NumReq)  index of current/last grant.
- busy_o  out  1  high in BUSY.
- timeout_o  out  1  one-cycle pulse on watchdog abort (tied 0 without macro).

Behaviour:
- Reset values:
  - State IDLE.
  - Round-robin pointer 0; gnt_idx_o 0.
  - All outputs 0; out_* data 0.
- Requester protocol: requester holds valid and fields stable until it sees in_ready_o[k].
- IDLE:
  - Winner is the first asserted in_valid_i at index ≥ pointer, wrapping to lower indices.
  - If any valid: register the winner into gnt_idx, go BUSY next cycle.
  - out_valid_o = 0 in IDLE.
- BUSY:
  - out_valid_o = in_valid_i[gnt_idx].
  - out_write/addr/wdata/wstrb combinationally muxed from gnt_idx; zeroed when out_valid_o = 0.
  - in_ready_o[gnt_idx] = out_ready_i in the same cycle; in_rdata_o/in_error_o pass through out_rdata_i/out_error_i.
  - in_ready_o of all other requesters = 0.
- Completion (out_ready_i & out_valid_o):
  - pointer = (gnt_idx+1) mod NumReq, wrapping NumReq-1 → 0.
  - Return to IDLE.
- Minimum per-transaction latency: 1 arbitration cycle + target latency. Back-to-back grants are separated by exactly one IDLE cycle.
- Abandon: if in_valid_i[gnt_idx] drops in BUSY without completion, return to IDLE next cycle; pointer unchanged; no ack issued.
- out_ready_i while out_valid_o = 0 is ignored.
- New requests during BUSY wait; non-granted inputs never reach the target.
- Asynchronous reset mid-transaction: immediate return to reset values; the in-flight transaction is dropped unacked.

Optional Feature:
- Macro REG_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TimeoutCycles+1), cleared on entering BUSY, incremented each BUSY cycle without completion.
  - When count == TimeoutCycles and out_ready_i = 0:
    - in_ready_o[gnt_idx] = 1, in_error_o = 1, in_rdata_o = 0.
    - timeout_o pulses; out_valid_o forced 0 in that cycle.
    - Pointer advances; go IDLE.
  - A completion in the same cycle as the timeout takes priority: normal ack, no timeout pulse.
- Undefined: no counter; BUSY waits indefinitely; timeout_o tied 0.

Decomposition:
- Package reg_rr_arbiter_pkg holds:
  - state enum {IDLE, BUSY}.
  - IdxWidth helper function (max(1, $clog2(NumReq))).
- Sub-module rr_ptr_select: combinational rotate-priority encoder.
  - Inputs: request vector, pointer.
  - Outputs: winner index, any-valid.
- FSM, counter and muxing stay in the top module.

Test Plan:
- Single requester 2 read, addr 0x10, target acks after 3 cycles with rdata 0xCAFE → out_valid_o 1 cycle after request; in_ready_o = 4'b0100 with rdata 0xCAFE; gnt_idx_o = 2; pointer → 3.
- Requesters 0 and 3 valid simultaneously from reset → grant order 0, 3; one IDLE cycle between grants.
- All 4 requesters continuously valid, zero-wait target → grant sequence 0,1,2,3,0,… repeating; wrap 3→0 verified.
- Requester 1 drops valid after 1 BUSY cycle → out_valid_o falls; FSM back to IDLE; no in_ready_o; next grant still starts search at 1.
- Macro on, TimeoutCycles=8, target never ready → after 8 BUSY cycles in_ready_o pulses with in_error_o = 1, rdata 0, timeout_o = 1.
- rst_ni asserted mid-BUSY → all outputs 0 immediately; after release, the pending request is re-granted from pointer 0.
